ctrl_pipereg: RTL and testbench

CTRL_PIPEREG -- requirements
Module: ctrl_pipereg

---
 rtl/ctrl_pipereg.sv | 123 ++++++++++++
 tb/tb_ctrl_pipereg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipereg.sv
// ctrl_pipereg: two-entry (main + skid) pipeline register for a control bundle.
// in_ready depends only on registered occupancy, so there is no combinational
// path from out_ready back to in_ready. An empty stage presents BUBBLE.
// Optional feature: define CTRL_PIPEREG_STATS_EN to add the stall_cnt and flush_cnt
// statistics outputs.
module ctrl_pipereg #(
  parameter int unsigned       WIDTH  = 8,
  parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CTRL_PIPEREG_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [7:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, transfer;

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // State and entry registers; reset empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and entry update; flush overrides everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (accept && transfer) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = StTwo;
            skid_d  = in_data;
          end else if (transfer) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
          end
        end
        StTwo: begin
          if (transfer) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Handshake outputs decoded from registered occupancy only.
  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q == StOne) || (state_q == StTwo);
    out_data  = out_valid ? main_q : BUBBLE;
  end

`ifdef CTRL_PIPEREG_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [7:0]  flush_cnt_q;

  // Saturating statistics counters; cleared only by reset, never by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 8'h00;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush && (flush_cnt_q != 8'hFF)) begin
        flush_cnt_q <= flush_cnt_q + 8'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipereg.sv
// Directed self-checking bench for ctrl_pipereg (WIDTH=8, BUBBLE=0).
module tb_ctrl_pipereg;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef CTRL_PIPEREG_STATS_EN
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  ctrl_pipereg #(
    .WIDTH  (8),
    .BUBBLE (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CTRL_PIPEREG_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'h00);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    do_reset();

    // Streaming: one bundle per cycle, 1-cycle latency, no gaps.
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      check_eq("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check_eq("stream_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stream_out_data", {24'd0, out_data}, i);
    end
    in_valid = 1'b0;
    step();
    check_eq("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill to TWO, hold, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    step();
    check_eq("bp_one_data", {24'd0, out_data}, 32'hA1);
    check_eq("bp_one_ready", {31'd0, in_ready}, 32'd1);
    in_data = 8'hA2;
    step();
    in_valid = 1'b0;
    check_eq("bp_two_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_two_data", {24'd0, out_data}, 32'hA1);
    step();
    check_eq("bp_hold_data", {24'd0, out_data}, 32'hA1);
    check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    check_eq("bp_first_data", {24'd0, out_data}, 32'hA1);
    check_eq("bp_ready_static", {31'd0, in_ready}, 32'd0);
    step();
    check_eq("bp_second_data", {24'd0, out_data}, 32'hA2);
    check_eq("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while in TWO with a same-cycle bundle offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB1;
    step();
    in_data = 8'hB2;
    step();
    check_eq("fl_pre_ready", {31'd0, in_ready}, 32'd0);
    flush   = 1'b1;
    in_data = 8'hB3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_out_data", {24'd0, out_data}, 32'h00);
    check_eq("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fl_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Flush in EMPTY with a same-cycle bundle: the bundle is discarded.
    in_valid = 1'b1;
    in_data  = 8'hB4;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_accept_dropped", {31'd0, out_valid}, 32'd0);

    // Async reset mid-cycle while in ONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    step();
    in_valid = 1'b0;
    check_eq("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ar_out_data", {24'd0, out_data}, 32'h00);
    check_eq("ar_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5C;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("ar_first_valid", {31'd0, out_valid}, 32'd1);
    check_eq("ar_first_data", {24'd0, out_data}, 32'h5C);

`ifdef CTRL_PIPEREG_STATS_EN
    do_reset();
    check_eq("st_rst_stall", {16'd0, stall_cnt}, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    check_eq("st_stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
    end
    check_eq("st_flush_cnt", {24'd0, flush_cnt}, 32'd3);
    check_eq("st_stall_kept", {16'd0, stall_cnt}, 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check_eq("st_rst_stall0", {16'd0, stall_cnt}, 32'd0);
    check_eq("st_rst_flush0", {24'd0, flush_cnt}, 32'd0);
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
